// File: rtl/mod2_pkg.sv
// mod2_pkg: shared types and default sizing for the mod2_0 radix-2 stage.
//   BF_DEPTH     - delay-line depth of each BF2I_4bundle butterfly (cycles)
//   FRAME_CYC    - input cycles per 512-point frame at 8 samples per cycle
//   ctrl_state_e - sequencer state, decoded for debug visibility
//   blk_idx_t    - sub-block index type sized for the default frame length
package mod2_pkg;

  localparam int BF_DEPTH   = 4;
  localparam int FRAME_CYC  = 64;
  localparam int BLK_IDX_W  = $clog2(FRAME_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_e;

  typedef logic [BLK_IDX_W-1:0] blk_idx_t;

endpackage

// File: rtl/valid_dly_line.sv
// valid_dly_line: DEPTH-stage 1-bit shift register used to delay strobes by
// the butterfly latency.
//   clk   - stage clock
//   rstn  - asynchronous active-low reset, clears every stage
//   din   - strobe entering the line
//   taps  - all stages; taps[0] is din delayed by one cycle,
//           taps[DEPTH-1] is din delayed by DEPTH cycles
module valid_dly_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its neighbour held before this edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      taps <= '0;
    end else begin
      taps <= {taps[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/mod2_0_ctrl.sv
// mod2_0_ctrl: sequencer for the mod2_0 radix-2 stage (four BF2I_4bundle
// butterflies sharing one control set).
//   clk          - stage clock
//   rstn         - asynchronous active-low reset
//   alert_cbfp1  - input sample valid, high FRAME_CYC cycles per frame
//   bf_en        - butterfly enable (input cycles plus DEPTH drain cycles)
//   bf_phase     - 0 = store / emit stored difference, 1 = butterfly compute
//   blk_idx      - input cycle index within the frame
//   dout_valid   - stage output valid, alert_cbfp1 delayed by DEPTH
//   frame_start  - first output cycle of a frame
//   frame_done   - last output cycle of a complete frame
//   err_gap      - one-cycle pulse after alert_cbfp1 drops mid-frame
//   busy         - sequencer not idle
module mod2_0_ctrl
  import mod2_pkg::*;
#(
  parameter int DEPTH     = mod2_pkg::BF_DEPTH,
  parameter int FRAME_CYC = mod2_pkg::FRAME_CYC,
  parameter int CNT_W     = $clog2(FRAME_CYC)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alert_cbfp1,
  output logic             bf_en,
  output logic             bf_phase,
  output logic [CNT_W-1:0] blk_idx,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             err_gap,
  output logic             busy
);

  localparam int DRN_W     = $clog2(DEPTH + 1);
  localparam int PHASE_BIT = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);

  logic             alert;
  logic             alert_q;
  logic [CNT_W-1:0] in_cnt,    in_cnt_nxt;
  logic [CNT_W-1:0] out_cnt,   out_cnt_nxt;
  logic [DRN_W-1:0] drain_cnt, drain_nxt;
  logic [DEPTH-1:0] vld_dly;
  logic [DEPTH-1:0] err_dly;
  logic             gap;
  ctrl_state_e      state;

  assign alert = alert_cbfp1;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alert_q   <= 1'b0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      alert_q   <= alert;
      in_cnt    <= in_cnt_nxt;
      out_cnt   <= out_cnt_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    drain_nxt   = '0;
    in_cnt_nxt  = '0;
    out_cnt_nxt = out_cnt;

    if (alert) begin
      state = RUN;
    end else if (drain_cnt != '0) begin
      state = DRAIN;
    end else begin
      state = IDLE;
    end

    case (state)
      RUN: begin
        // A rising alert during DRAIN lands here too: the drain is dropped.
        drain_nxt  = '0;
        in_cnt_nxt = (in_cnt == CNT_LAST) ? '0 : in_cnt + CNT_W'(1);
      end
      DRAIN: begin
        drain_nxt = drain_cnt - DRN_W'(1);
      end
      default: begin
        // The falling-edge cycle already decodes as IDLE because alert is
        // low; alert_q still marks it, and the drain window is armed here.
        drain_nxt = alert_q ? DRN_W'(DEPTH) : '0;
      end
    endcase

    // Error resync wins: the partial frame's output count is abandoned at
    // the exact output cycle that follows its last valid sample.
    if (err_dly[DEPTH-1]) begin
      out_cnt_nxt = '0;
    end else if (dout_valid) begin
      out_cnt_nxt = (out_cnt == CNT_LAST) ? '0 : out_cnt + CNT_W'(1);
    end
  end

  // A drop that does not land on a frame boundary is a broken frame.
  assign gap = !alert && alert_q && (in_cnt != '0);

  // ---------------------------------------------------------------------
  // Strobe delay lines (output valid and error resync)
  // ---------------------------------------------------------------------
  valid_dly_line #(.DEPTH(DEPTH)) u_vld_dly (
    .clk  (clk),
    .rstn (rstn),
    .din  (alert),
    .taps (vld_dly)
  );

  valid_dly_line #(.DEPTH(DEPTH)) u_err_dly (
    .clk  (clk),
    .rstn (rstn),
    .din  (gap),
    .taps (err_dly)
  );

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bf_en       = (state != IDLE);
    busy        = (state != IDLE);
    // Compute phase only while samples arrive; the drain only emits the
    // stored differences.
    bf_phase    = (state == RUN) && in_cnt[PHASE_BIT];
    blk_idx     = in_cnt;
    dout_valid  = vld_dly[DEPTH-1];
    frame_start = dout_valid && (out_cnt == '0);
    frame_done  = dout_valid && (out_cnt == CNT_LAST);
    err_gap     = err_dly[0];
  end

endmodule

// File: tb/tb_mod2_0_ctrl.sv
// tb_mod2_0_ctrl: scoreboard bench for mod2_0_ctrl. The driver applies
// alert_cbfp1 patterns, checks the same-cycle control outputs against a
// frame-position model and queues the expected output beats; a monitor
// pops and compares them when the DUT presents dout_valid.
module tb_mod2_0_ctrl;
  import mod2_pkg::*;

  localparam int D  = BF_DEPTH;
  localparam int FC = FRAME_CYC;
  localparam int CW = $clog2(FC);
  localparam int PB = $clog2(D);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          alert = 1'b0;
  logic          bf_en, bf_phase, dout_valid, frame_start, frame_done;
  logic          err_gap, busy;
  blk_idx_t      blk_idx;

  mod2_0_ctrl #(.DEPTH(D), .FRAME_CYC(FC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .alert_cbfp1 (alert),
    .bf_en       (bf_en),
    .bf_phase    (bf_phase),
    .blk_idx     (blk_idx),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .err_gap     (err_gap),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int due;
    bit start;
    bit done;
  } beat_t;

  beat_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Model: run = consecutive alert cycles just before the current cycle,
  // last_hi = cycle of the latest alert, err_pend = gap seen last cycle.
  int run      = 0;
  int last_hi  = -100;
  bit err_pend = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " bf_en"},       bf_en,       0);
    check({tag, " bf_phase"},    bf_phase,    0);
    check({tag, " blk_idx"},     blk_idx,     0);
    check({tag, " dout_valid"},  dout_valid,  0);
    check({tag, " frame_start"}, frame_start, 0);
    check({tag, " frame_done"},  frame_done,  0);
    check({tag, " err_gap"},     err_gap,     0);
    check({tag, " busy"},        busy,        0);
  endtask

  task automatic model_reset();
    sb.delete();
    run      = 0;
    last_hi  = -100;
    err_pend = 1'b0;
  endtask

  // One input cycle with alert = a.
  task automatic step(input bit a);
    int    pos;
    int    since;
    bit    en;
    beat_t b;
    @(posedge clk);
    #1;
    alert = a;
    pos   = run % FC;
    since = cyc - last_hi;
    // Enabled on every sample cycle and for D cycles of drain, which start
    // one cycle after the drop.
    en    = a || (since >= 2 && since <= D + 1);
    if (a) begin
      b.due   = cyc + D;
      b.start = (pos == 0);
      b.done  = (pos == FC - 1);
      sb.push_back(b);
    end
    @(negedge clk);
    check("bf_en",    bf_en,    en);
    check("busy",     busy,     en);
    check("blk_idx",  blk_idx,  pos);
    check("bf_phase", bf_phase, a && ((pos >> PB) & 1));
    check("err_gap",  err_gap,  err_pend);
    err_pend = !a && (run > 0) && (pos != 0);
    if (a) begin
      run++;
      last_hi = cyc;
    end else begin
      run = 0;
    end
  endtask

  task automatic burst(input int n_hi, input int n_lo);
    repeat (n_hi) step(1'b1);
    repeat (n_lo) step(1'b0);
  endtask

  // Reset pulse of 1.5 cycles that starts and ends away from any edge.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rstn  = 1'b0;
    alert = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_reset");
    #14;
    rstn = 1'b1;
  endtask

  // Monitor: every cycle, dout_valid must match whether a beat is due, and
  // the frame markers must match that beat.
  always @(negedge clk) begin
    if (rstn) begin : mon
      bit    ev;
      beat_t b;
      ev = (sb.size() > 0) && (sb[0].due == cyc);
      check("dout_valid", dout_valid, ev);
      if (ev) begin
        b = sb.pop_front();
        check("frame_start", frame_start, b.start);
        check("frame_done",  frame_done,  b.done);
      end else begin
        check("frame_start_idle", frame_start, 0);
        check("frame_done_idle",  frame_done,  0);
      end
    end
  end

  initial begin
    #12;
    check_all_zero("reset");
    #11;
    rstn = 1'b1;
    repeat (3) step(1'b0);

    burst(FC, 8);              // single frame
    burst(2 * FC, 8);          // back-to-back frames
    burst(20, 3);              // broken frame at in_cnt = 20
    burst(FC, 8);              // recovery frame
    burst(FC, 2);              // restart two cycles into the drain
    burst(FC, 8);
    repeat (37) step(1'b1);    // reset at in_cnt = 37
    reset_mid();
    repeat (2) step(1'b0);
    burst(FC, 8);              // first frame after reset

    repeat (14) begin
      burst($urandom_range(1, 150), $urandom_range(1, 6));
    end
    repeat (10) step(1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod2_0_ctrl.md
Name: mod2_0_ctrl

Overview:
- Sequencer for the mod2_0 radix-2 stage, which contains four BF2I_4bundle butterflies of delay depth 4.
- Takes the upstream CBFP valid strobe (alert_cbfp1) and generates, for all four butterflies:
  - a shared enable and store/compute phase,
  - a sub-block index,
  - a DEPTH-delayed output valid with frame-start and frame-done markers.
- Detects broken input frames and flushes the butterfly delay lines.

Parameters:
- DEPTH, 4, butterfly delay-line depth in cycles; power of two, at least 2.
- FRAME_CYC, 64, input cycles per frame (512 points at 8 samples per cycle); power of two and a multiple of 2*DEPTH.
- CNT_W, $clog2(FRAME_CYC), width of the frame counters.

Ports:
- clk  in  1  stage clock.
- rstn  in  1  asynchronous active-low reset.
- alert_cbfp1  in  1  input sample valid; held high for FRAME_CYC consecutive cycles per frame.
- bf_en  out  1  butterfly enable, driven to all four BF2I_4bundle instances.
- bf_phase  out  1  0 = store into delay line / emit stored difference; 1 = butterfly compute.
- blk_idx  out  CNT_W  input cycle index within the frame.
- dout_valid  out  1  stage output valid.
- frame_start  out  1  pulse on the first dout_valid cycle of a frame.
- frame_done  out  1  pulse on the last dout_valid cycle of a frame.
- err_gap  out  1  pulse when alert_cbfp1 drops mid-frame.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: all registers clear. Every output is 0 and state is IDLE.
- Registers:
  - in_cnt[CNT_W]
  - drain_cnt[$clog2(DEPTH+1)]
  - vld_dly[DEPTH], a shift line of alert_cbfp1
  - err_dly[DEPTH], a shift line of the gap flag
  - out_cnt[CNT_W]
  - alert_q
- States:
  - IDLE: alert=0 and drain_cnt=0.
  - RUN: alert=1.
  - DRAIN: alert=0 and drain_cnt!=0.
- Transitions:
  - IDLE to RUN when alert=1.
  - RUN to DRAIN on alert falling edge; drain_cnt is loaded with DEPTH.
  - DRAIN decrements drain_cnt each cycle. It goes to RUN if alert rises (drain is abandoned and drain_cnt cleared), otherwise to IDLE when drain_cnt reaches 1.
- in_cnt:
  - Increments on every cycle with alert=1.
  - Wraps from FRAME_CYC-1 to 0, so back-to-back frames need no idle cycle.
  - Cleared in any cycle with alert=0.
- Outputs derived from registered state; they are combinational and aligned with the input data cycle:
  - bf_en = alert | (drain_cnt!=0).
  - bf_phase = alert & in_cnt[$clog2(DEPTH)]; in DRAIN it is forced to 0.
  - blk_idx = in_cnt.
- Gap detection:
  - gap = alert=0 & alert_q=1 & in_cnt!=0.
  - err_gap is registered: it is a 1-cycle pulse in the cycle after the drop.
  - The drain still runs, so partial data is flushed.
- Output valid:
  - dout_valid = vld_dly[DEPTH-1].
  - Latency from alert_cbfp1 to dout_valid is exactly DEPTH cycles.
- out_cnt:
  - Increments when dout_valid=1 and wraps at FRAME_CYC-1.
  - Forced to 0 when err_dly[DEPTH-1]=1; this takes priority over increment.
- Frame markers:
  - frame_start = dout_valid & out_cnt==0.
  - frame_done = dout_valid & out_cnt==FRAME_CYC-1.
  - A partial frame produces no frame_done.
- Simultaneous events: a gap and a new frame start one cycle apart are handled independently. err_dly resyncs out_cnt at the correct output cycle.
- Reset mid-frame: everything clears immediately and all outputs go to 0. Delay-line contents in the butterflies are don't-care.

Decomposition:
- Package mod2_pkg holds:
  - localparams BF_DEPTH=4 and FRAME_CYC=64;
  - typedef ctrl_state_e {IDLE, RUN, DRAIN}, used for debug visibility;
  - typedef blk_idx_t.
- One sub-module, valid_dly_line: a parameterised DEPTH-stage 1-bit shift register, instantiated twice (valid and error).

Test Plan:
- Reset, then one frame: alert high for 64 cycles, then low.
  - bf_phase pattern is 0000_1111 repeating.
  - dout_valid rises 4 cycles after alert rises and is high for 64 cycles.
  - frame_start coincides with the first valid cycle; frame_done with the 64th.
  - bf_en is high for 68 cycles; busy falls after the drain.
- Back-to-back frames: alert high for 128 cycles.
  - blk_idx wraps 63 to 0 with no bubble.
  - Two frame_start and two frame_done pulses, 64 cycles apart; no err_gap.
- Gap at in_cnt=20: alert drops for 3 cycles, then a full frame.
  - err_gap pulses once.
  - No frame_done for the partial frame.
  - The next frame's frame_start occurs 4 cycles after its alert rise, with out_cnt restarted at 0.
- Re-start during DRAIN: alert falls after 64 cycles and rises 2 cycles later.
  - drain_cnt clears and blk_idx restarts at 0.
  - dout_valid has exactly a 2-cycle hole.
- Asynchronous reset asserted at in_cnt=37 for a non-edge-aligned 1.5 cycles.
  - All outputs go to 0 immediately.
  - The first post-reset frame behaves exactly as in the single-frame scenario.
